getir1_kuyruklu: RTL and testbench

//  Parametrised fetch-stage-1 PC generator. Sustains up to KUYRUK_DERINLIK outstanding L1I requests.

---
 rtl/getir1_kuyruklu_if.sv | 40 ++++
 rtl/getir1_kuyruklu.sv | 116 +++++++++++
 tb/tb_getir1_kuyruklu.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/getir1_kuyruklu_if.sv
// Handshake bundle between fetch stage 1, the L1 instruction cache, Getir2 and the core redirect port.
// The master side is the PC generator; the slave side is everything around it.
interface getir1_kuyruklu_if #(
  parameter int PS_BIT          = 32,
  parameter int ETIKET_BIT      = 2,
  parameter int KUYRUK_DERINLIK = 4
) ();
  localparam int DOL_BIT = $clog2(KUYRUK_DERINLIK + 1);

  logic                  l1b_istek_hazir_i;
  logic                  l1b_istek_gecerli_o;
  logic [PS_BIT-1:0]     l1b_istek_adres_o;
  logic [ETIKET_BIT-1:0] l1b_istek_etiket_o;
  logic                  g2_istek_yapildi_o;
  logic [PS_BIT-1:0]     g2_ps_o;
  logic [ETIKET_BIT-1:0] g2_ps_etiket_o;
  logic                  g2_ps_gecerli_o;
  logic                  g2_ps_hazir_i;
  logic [PS_BIT-1:0]     cek_ps_i;
  logic                  cek_ps_gecerli_i;
  logic                  cek_bosalt_i;
  logic                  cek_duraklat_i;
  logic [DOL_BIT-1:0]    kuyruk_doluluk_o;

  modport master (
    input  l1b_istek_hazir_i, g2_ps_hazir_i, cek_ps_i, cek_ps_gecerli_i,
           cek_bosalt_i, cek_duraklat_i,
    output l1b_istek_gecerli_o, l1b_istek_adres_o, l1b_istek_etiket_o,
           g2_istek_yapildi_o, g2_ps_o, g2_ps_etiket_o, g2_ps_gecerli_o,
           kuyruk_doluluk_o
  );

  modport slave (
    output l1b_istek_hazir_i, g2_ps_hazir_i, cek_ps_i, cek_ps_gecerli_i,
           cek_bosalt_i, cek_duraklat_i,
    input  l1b_istek_gecerli_o, l1b_istek_adres_o, l1b_istek_etiket_o,
           g2_istek_yapildi_o, g2_ps_o, g2_ps_etiket_o, g2_ps_gecerli_o,
           kuyruk_doluluk_o
  );
endinterface

// File: rtl/getir1_kuyruklu.sv
// Fetch stage 1 PC generator: issues aligned L1I requests and records {PC, tag} of every accepted
// request in an in-order queue that Getir2 drains; a flushing redirect bumps the tag.
module getir1_kuyruklu #(
  parameter int                PS_BIT          = 32,
  parameter int                BUYRUK_BAYT     = 4,
  parameter int                KUYRUK_DERINLIK = 4,
  parameter int                ETIKET_BIT      = 2,
  parameter logic [PS_BIT-1:0] BASLANGIC_PS    = PS_BIT'(32'h4000_0000)
) (
  input logic                clk_i,
  input logic                rst_i,
  getir1_kuyruklu_if.master  bus
);
  localparam int                PTR_BIT    = $clog2(KUYRUK_DERINLIK);
  localparam int                DOL_BIT    = $clog2(KUYRUK_DERINLIK + 1);
  localparam logic [PS_BIT-1:0] ADIM       = PS_BIT'(BUYRUK_BAYT);
  localparam logic [PS_BIT-1:0] HIZA_MASKE = ~PS_BIT'(BUYRUK_BAYT - 1);
  localparam logic [DOL_BIT-1:0] DOLU      = DOL_BIT'(KUYRUK_DERINLIK);

  logic [PS_BIT-1:0]     ps_q, ps_d;
  logic [ETIKET_BIT-1:0] etiket_q, etiket_d;
  logic [PTR_BIT-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_BIT-1:0]    wr_ptr_q, wr_ptr_d;
  logic [DOL_BIT-1:0]    count_q, count_d;
  logic [PS_BIT-1:0]     ps_mem_q  [KUYRUK_DERINLIK];
  logic [PS_BIT-1:0]     ps_mem_d  [KUYRUK_DERINLIK];
  logic [ETIKET_BIT-1:0] etk_mem_q [KUYRUK_DERINLIK];
  logic [ETIKET_BIT-1:0] etk_mem_d [KUYRUK_DERINLIK];

  logic                  yonlen;
  logic                  bosalt;
  logic [PS_BIT-1:0]     ps_cmb;
  logic [PS_BIT-1:0]     adres_cmb;
  logic [ETIKET_BIT-1:0] etk_cmb;
  logic                  yer_var;
  logic                  istek_gecerli;
  logic                  push;
  logic                  pop;
  logic                  bos_degil;

  // Room is judged on the registered count only, so L1I readiness never feeds back into valid.
  always_comb begin
    yonlen        = bus.cek_ps_gecerli_i;
    bosalt        = bus.cek_ps_gecerli_i & bus.cek_bosalt_i;
    ps_cmb        = yonlen ? bus.cek_ps_i : ps_q;
    adres_cmb     = ps_cmb & HIZA_MASKE;
    etk_cmb       = bosalt ? etiket_q + ETIKET_BIT'(1) : etiket_q;
    yer_var       = bosalt | (count_q < DOLU);
    istek_gecerli = ~rst_i & yer_var & (yonlen | ~bus.cek_duraklat_i);
    push          = bus.l1b_istek_hazir_i & istek_gecerli;
    bos_degil     = ~rst_i & (count_q != '0);
    pop           = bus.g2_ps_hazir_i & bos_degil & ~bosalt;
  end

  always_comb begin
    ps_d      = ps_q;
    etiket_d  = etk_cmb;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    ps_mem_d  = ps_mem_q;
    etk_mem_d = etk_mem_q;

    if (push) begin
      ps_d                = adres_cmb + ADIM;
      ps_mem_d[wr_ptr_q]  = ps_cmb;
      etk_mem_d[wr_ptr_q] = etk_cmb;
      wr_ptr_d            = wr_ptr_q + PTR_BIT'(1);
    end else if (yonlen) begin
      ps_d = bus.cek_ps_i;
    end

    // A flush empties the queue by snapping the read pointer onto the old tail.
    if (bosalt) begin
      rd_ptr_d = wr_ptr_q;
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_BIT'(1);
    end

    count_d = (bosalt ? '0 : count_q - DOL_BIT'(pop)) + DOL_BIT'(push);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ps_q     <= BASLANGIC_PS;
      etiket_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ps_q     <= ps_d;
      etiket_q <= etiket_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: it is only visible while the count says it is valid.
  always_ff @(posedge clk_i) begin
    ps_mem_q  <= ps_mem_d;
    etk_mem_q <= etk_mem_d;
  end

  assign bus.l1b_istek_gecerli_o = istek_gecerli;
  assign bus.l1b_istek_adres_o   = adres_cmb;
  assign bus.l1b_istek_etiket_o  = etk_cmb;
  assign bus.g2_istek_yapildi_o  = push;
  assign bus.g2_ps_gecerli_o     = bos_degil;
  assign bus.g2_ps_o             = ps_mem_q[rd_ptr_q];
  assign bus.g2_ps_etiket_o      = etk_mem_q[rd_ptr_q];
  assign bus.kuyruk_doluluk_o    = rst_i ? '0 : count_q;

  a_doluluk_sinir: assert property (@(posedge clk_i) disable iff (rst_i) count_q <= DOLU);
  a_dolu_itme: assert property (@(posedge clk_i) disable iff (rst_i)
                                 (push && !bosalt) |-> (count_q != DOLU));
endmodule

// File: tb/tb_getir1_kuyruklu.sv
// Directed vector bench for getir1_kuyruklu: one table row per clock cycle, inputs driven on the
// falling edge and outputs compared shortly after, plus a tag-wrap sequence built in a loop.
module tb_getir1_kuyruklu;
  localparam logic [31:0] B = 32'h4000_0000;

  typedef struct {
    logic        r, lh, gh;
    logic [31:0] cp;
    logic        cv, cb, st;
    logic        v;
    logic [31:0] a;
    logic [1:0]  e;
    logic        y, gv;
    logic [31:0] gp;
    logic [1:0]  ge;
    logic [2:0]  d;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec_cnt = 0;
  int   miss_cnt = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  getir1_kuyruklu_if #(.PS_BIT(32), .ETIKET_BIT(2), .KUYRUK_DERINLIK(4)) bus_if ();

  getir1_kuyruklu #(
    .PS_BIT(32), .BUYRUK_BAYT(4), .KUYRUK_DERINLIK(4), .ETIKET_BIT(2), .BASLANGIC_PS(B)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus_if)
  );

  function automatic vec_t mk(input logic r, lh, gh, input logic [31:0] cp,
                              input logic cv, cb, st, input logic v, input logic [31:0] a,
                              input logic [1:0] e, input logic y, gv, input logic [31:0] gp,
                              input logic [1:0] ge, input logic [2:0] d);
    vec_t t;
    t.r = r; t.lh = lh; t.gh = gh; t.cp = cp; t.cv = cv; t.cb = cb; t.st = st;
    t.v = v; t.a = a; t.e = e; t.y = y; t.gv = gv; t.gp = gp; t.ge = ge; t.d = d;
    return t;
  endfunction

  task automatic apply_stimulus(input vec_t t);
    @(negedge clk);
    rst                      = t.r;
    bus_if.l1b_istek_hazir_i = t.lh;
    bus_if.g2_ps_hazir_i     = t.gh;
    bus_if.cek_ps_i          = t.cp;
    bus_if.cek_ps_gecerli_i  = t.cv;
    bus_if.cek_bosalt_i      = t.cb;
    bus_if.cek_duraklat_i    = t.st;
    #1;
  endtask

  task automatic check_field(input int idx, input string nm, input logic [31:0] got,
                             input logic [31:0] want);
    if (got !== want) begin
      miss_cnt++;
      $display("[TB] FAIL v%0d %s got %h want %h", idx, nm, got, want);
    end
  endtask

  task automatic check_output(input int idx, input vec_t t);
    vec_cnt++;
    check_field(idx, "gecerli", 32'(bus_if.l1b_istek_gecerli_o), 32'(t.v));
    check_field(idx, "yapildi", 32'(bus_if.g2_istek_yapildi_o), 32'(t.y));
    check_field(idx, "g2_gecerli", 32'(bus_if.g2_ps_gecerli_o), 32'(t.gv));
    check_field(idx, "doluluk", 32'(bus_if.kuyruk_doluluk_o), 32'(t.d));
    if (!t.r) begin
      check_field(idx, "adres", bus_if.l1b_istek_adres_o, t.a);
      check_field(idx, "etiket", 32'(bus_if.l1b_istek_etiket_o), 32'(t.e));
    end
    if (t.gv) begin
      check_field(idx, "g2_ps", bus_if.g2_ps_o, t.gp);
      check_field(idx, "g2_etiket", 32'(bus_if.g2_ps_etiket_o), 32'(t.ge));
    end
  endtask

  initial begin
    bus_if.l1b_istek_hazir_i = 1'b0;
    bus_if.g2_ps_hazir_i     = 1'b0;
    bus_if.cek_ps_i          = '0;
    bus_if.cek_ps_gecerli_i  = 1'b0;
    bus_if.cek_bosalt_i      = 1'b0;
    bus_if.cek_duraklat_i    = 1'b0;

    //                r  lh gh cp             cv cb st  v  a              e  y  gv gp             ge d
    tbl.push_back(mk(1, 0, 0, 0,             0, 0, 0,  0, 0,             0, 0, 0, 0,             0, 0));
    tbl.push_back(mk(1, 0, 0, 0,             0, 0, 0,  0, 0,             0, 0, 0, 0,             0, 0));
    // steady issue and drain after reset release
    tbl.push_back(mk(0, 1, 1, 0,             0, 0, 0,  1, B,             0, 1, 0, 0,             0, 0));
    tbl.push_back(mk(0, 1, 1, 0,             0, 0, 0,  1, B+4,           0, 1, 1, B,             0, 1));
    tbl.push_back(mk(0, 1, 1, 0,             0, 0, 0,  1, B+8,           0, 1, 1, B+4,           0, 1));
    tbl.push_back(mk(1, 1, 1, 0,             0, 0, 0,  0, 0,             0, 0, 0, 0,             0, 0));
    // fill to capacity with Getir2 stalled
    tbl.push_back(mk(0, 1, 0, 0,             0, 0, 0,  1, B,             0, 1, 0, 0,             0, 0));
    tbl.push_back(mk(0, 1, 0, 0,             0, 0, 0,  1, B+4,           0, 1, 1, B,             0, 1));
    tbl.push_back(mk(0, 1, 0, 0,             0, 0, 0,  1, B+8,           0, 1, 1, B,             0, 2));
    tbl.push_back(mk(0, 1, 0, 0,             0, 0, 0,  1, B+12,          0, 1, 1, B,             0, 3));
    tbl.push_back(mk(0, 1, 0, 0,             0, 0, 0,  0, B+16,          0, 0, 1, B,             0, 4));
    tbl.push_back(mk(0, 1, 1, 0,             0, 0, 0,  0, B+16,          0, 0, 1, B,             0, 4));
    tbl.push_back(mk(0, 1, 0, 0,             0, 0, 0,  1, B+16,          0, 1, 1, B+4,           0, 3));
    // flushing redirect on a full queue, head pop ignored
    tbl.push_back(mk(0, 1, 1, 32'h8000_0006, 1, 1, 0,  1, 32'h8000_0004, 1, 1, 1, B+4,           0, 4));
    tbl.push_back(mk(0, 0, 0, 0,             0, 0, 0,  1, 32'h8000_0008, 1, 0, 1, 32'h8000_0006, 1, 1));
    // redirect under stall keeps queued entries; draining continues while stalled
    tbl.push_back(mk(0, 1, 0, 32'h0000_0100, 1, 0, 1,  1, 32'h0000_0100, 1, 1, 1, 32'h8000_0006, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0,             0, 0, 1,  0, 32'h0000_0104, 1, 0, 1, 32'h8000_0006, 1, 2));
    tbl.push_back(mk(0, 1, 1, 0,             0, 0, 1,  0, 32'h0000_0104, 1, 0, 1, 32'h8000_0006, 1, 2));
    tbl.push_back(mk(0, 1, 0, 0,             0, 0, 1,  0, 32'h0000_0104, 1, 0, 1, 32'h0000_0100, 1, 1));
    // PC wrap past the top of the address space
    tbl.push_back(mk(0, 1, 0, 32'hFFFF_FFFC, 1, 0, 0,  1, 32'hFFFF_FFFC, 1, 1, 1, 32'h0000_0100, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0,             0, 0, 0,  1, 32'h0000_0000, 1, 1, 1, 32'h0000_0100, 1, 2));
    // back-to-back flushes, tag 1 -> 2 -> 3 -> 0
    tbl.push_back(mk(0, 0, 0, 32'h0000_0200, 1, 1, 0,  1, 32'h0000_0200, 2, 0, 1, 32'hFFFF_FFFC, 1, 2));
    tbl.push_back(mk(0, 1, 0, 32'h0000_0300, 1, 1, 0,  1, 32'h0000_0300, 3, 1, 0, 0,             0, 0));
    tbl.push_back(mk(0, 1, 1, 32'h0000_0400, 1, 1, 0,  1, 32'h0000_0400, 0, 1, 1, 32'h0000_0300, 3, 1));
    // reset in the middle of traffic
    tbl.push_back(mk(0, 1, 0, 0,             0, 0, 0,  1, 32'h0000_0404, 0, 1, 1, 32'h0000_0400, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0,             0, 0, 0,  1, 32'h0000_0408, 0, 1, 1, 32'h0000_0400, 0, 2));
    tbl.push_back(mk(1, 1, 0, 0,             0, 0, 0,  0, 0,             0, 0, 0, 0,             0, 0));
    tbl.push_back(mk(0, 0, 0, 0,             0, 0, 0,  1, B,             0, 0, 0, 0,             0, 0));
    tbl.push_back(mk(0, 1, 0, 0,             0, 0, 0,  1, B,             0, 1, 0, 0,             0, 0));
    tbl.push_back(mk(0, 0, 0, 0,             0, 0, 0,  1, B+4,           0, 0, 1, B,             0, 1));
    // flush request without a redirect strobe does nothing
    tbl.push_back(mk(0, 0, 0, 0,             0, 1, 0,  1, B+4,           0, 0, 1, B,             0, 1));
    tbl.push_back(mk(0, 0, 0, 0,             0, 0, 0,  1, B+4,           0, 0, 1, B,             0, 1));

    foreach (tbl[i]) begin
      apply_stimulus(tbl[i]);
      check_output(i, tbl[i]);
    end

    // Four flushing redirects from tag 0 with unaligned targets: tag must come back to 0
    for (int k = 0; k < 4; k++) begin
      vec_t t;
      logic [31:0] tgt;
      tgt = 32'h0000_1003 + 32'(k) * 32'h10;
      t = mk(0, 0, 0, tgt, 1, 1, 0, 1, tgt & 32'hFFFF_FFFC, 2'(k + 1), 0,
             (k == 0), B, 0, (k == 0) ? 3'd1 : 3'd0);
      apply_stimulus(t);
      check_output(100 + k, t);
    end
    begin
      vec_t t;
      t = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_1030, 0, 0, 0, 0, 0, 0);
      apply_stimulus(t);
      check_output(104, t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
